// File: rtl/alu_pkg.sv
// Shared ALU definitions for the EX-side pipeline.
// Holds the ALU opcode encodings, the highest defined opcode (anything above
// it is flagged illegal by the operand stage), the default datapath widths and
// the operand-stage handshake state encoding.
package alu_pkg;

  localparam int WL_DEF   = 32;
  localparam int RW_DEF   = 5;
  localparam int SELW_DEF = 4;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLL1 = 2;
  localparam int OP_SRL1 = 3;
  localparam int OP_SLLV = 4;
  localparam int OP_SRLV = 5;
  localparam int OP_SRA  = 6;
  localparam int OP_AND  = 7;
  localparam int OP_OR   = 8;
  localparam int OP_XOR  = 9;
  localparam int OP_XNOR = 10;

  localparam int SEL_MAX = OP_XNOR;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

endpackage

// File: rtl/fwd_mux.sv
// Single-operand forwarding priority mux.
// Ports:
//   src      in   RW  source register index
//   reg_val  in   WL  value to use when nothing forwards
//   mem_en   in   1   MEM result valid
//   mem_rd   in   RW  MEM destination
//   mem_data in   WL  MEM result
//   wb_en    in   1   WB result valid
//   wb_rd    in   RW  WB destination
//   wb_data  in   WL  WB result
//   fwd_val  out  WL  resolved operand
// Priority: register 0 reads as zero, then MEM (youngest), then WB, then reg_val.
module fwd_mux #(
  parameter int RW = 5,
  parameter int WL = 32
) (
  input  logic [RW-1:0] src,
  input  logic [WL-1:0] reg_val,
  input  logic          mem_en,
  input  logic [RW-1:0] mem_rd,
  input  logic [WL-1:0] mem_data,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_rd,
  input  logic [WL-1:0] wb_data,
  output logic [WL-1:0] fwd_val
);

  always_comb begin
    fwd_val = reg_val;
    if (src == '0) begin
      fwd_val = '0;
    end else if (mem_en && (mem_rd == src)) begin
      fwd_val = mem_data;
    end else if (wb_en && (wb_rd == src)) begin
      fwd_val = wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage feeding the ALU.
// Captures a decoded op through a valid/ready handshake, resolves RAW hazards
// by forwarding from MEM and WB, selects register or immediate for operand B
// and presents registered sel/a/b/rd/wen to the ALU. While an op is held
// (out_valid && !out_ready) forwarding keeps running on the held indices so the
// held operands track late-arriving producer results.
// Ports:
//   clk, rst (sync, active-low), flush (drops held and incoming op)
//   in_valid/in_ready, in_sel, in_rs1/in_rs2, in_rs1_val/in_rs2_val,
//   in_imm, in_use_imm, in_rd, in_wen                      -- upstream op
//   mem_fwd_en/rd/data, wb_fwd_en/rd/data                  -- forwarding sources
//   out_valid/out_ready, out_sel, out_a, out_b, out_rd,
//   out_wen, out_illegal                                   -- toward ALU
module ex_operand_stage
  import alu_pkg::*;
#(
  parameter int WL   = WL_DEF,
  parameter int RW   = RW_DEF,
  parameter int SELW = SELW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SELW-1:0] in_sel,
  input  logic [RW-1:0]   in_rs1,
  input  logic [RW-1:0]   in_rs2,
  input  logic [WL-1:0]   in_rs1_val,
  input  logic [WL-1:0]   in_rs2_val,
  input  logic [WL-1:0]   in_imm,
  input  logic            in_use_imm,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_wen,
  input  logic            mem_fwd_en,
  input  logic [RW-1:0]   mem_fwd_rd,
  input  logic [WL-1:0]   mem_fwd_data,
  input  logic            wb_fwd_en,
  input  logic [RW-1:0]   wb_fwd_rd,
  input  logic [WL-1:0]   wb_fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_sel,
  output logic [WL-1:0]   out_a,
  output logic [WL-1:0]   out_b,
  output logic [RW-1:0]   out_rd,
  output logic            out_wen,
  output logic            out_illegal
);

  stage_state_e    state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [WL-1:0]   a_q, a_d;
  logic [WL-1:0]   b_q, b_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic            wen_q, wen_d;
  logic            ill_q, ill_d;
  logic [RW-1:0]   rs1_q, rs1_d;
  logic [RW-1:0]   rs2_q, rs2_d;
  logic            use_imm_q, use_imm_d;

  logic            accept;
  logic            hold;
  logic [WL-1:0]   cap_a_val, cap_b_val;
  logic [WL-1:0]   hold_a_val, hold_b_val;

  assign out_valid   = (state_q == ST_FULL);
  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready;
  assign hold        = out_valid && !out_ready;

  assign out_sel     = sel_q;
  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_rd      = rd_q;
  assign out_wen     = wen_q;
  assign out_illegal = ill_q;

  // Capture-path forwarding on the incoming indices
  fwd_mux #(.RW(RW), .WL(WL)) u_fwd_cap_a (
    .src(in_rs1), .reg_val(in_rs1_val),
    .mem_en(mem_fwd_en), .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
    .wb_en(wb_fwd_en), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .fwd_val(cap_a_val)
  );

  fwd_mux #(.RW(RW), .WL(WL)) u_fwd_cap_b (
    .src(in_rs2), .reg_val(in_rs2_val),
    .mem_en(mem_fwd_en), .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
    .wb_en(wb_fwd_en), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .fwd_val(cap_b_val)
  );

  // Hold-refresh forwarding: held operands act as the fallback register value
  fwd_mux #(.RW(RW), .WL(WL)) u_fwd_hold_a (
    .src(rs1_q), .reg_val(a_q),
    .mem_en(mem_fwd_en), .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
    .wb_en(wb_fwd_en), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .fwd_val(hold_a_val)
  );

  fwd_mux #(.RW(RW), .WL(WL)) u_fwd_hold_b (
    .src(rs2_q), .reg_val(b_q),
    .mem_en(mem_fwd_en), .mem_rd(mem_fwd_rd), .mem_data(mem_fwd_data),
    .wb_en(wb_fwd_en), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data),
    .fwd_val(hold_b_val)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    wen_d     = wen_q;
    ill_d     = ill_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    use_imm_d = use_imm_q;

    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)         state_d = ST_FULL;
        else if (out_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase

    // flush dominates: the held op is killed and an op accepted this cycle is not loaded
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      sel_d     = in_sel;
      a_d       = cap_a_val;
      b_d       = in_use_imm ? in_imm : cap_b_val;
      rd_d      = in_rd;
      wen_d     = in_wen;
      ill_d     = (in_sel > SELW'(SEL_MAX));
      rs1_d     = in_rs1;
      rs2_d     = in_rs2;
      use_imm_d = in_use_imm;
    end else if (hold) begin
      a_d = hold_a_val;
      // an immediate operand B has no producer, so it is never refreshed
      if (!use_imm_q) b_d = hold_b_val;
    end
  end

  // Stage register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      sel_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      ill_q     <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_imm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      ill_q     <= ill_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      use_imm_q <= use_imm_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [3:0]  in_sel;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic        in_use_imm, in_wen;
  logic        mem_fwd_en, wb_fwd_en;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        out_valid, out_ready, out_wen, out_illegal;
  logic [3:0]  out_sel;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_rd;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd), .in_wen(in_wen),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wen(out_wen),
    .out_illegal(out_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake on the output side must match the oldest expected op
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_sel", {28'd0, out_sel}, {28'd0, e.sel});
        chk("out_a", out_a, e.a);
        chk("out_b", out_b, e.b);
        chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
        chk("out_wen", {31'd0, out_wen}, {31'd0, e.wen});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      end
    end
  end

  // Present an op, wait (bounded) for in_ready, record the expected result.
  // Leaves in_valid asserted so consecutive calls stream back-to-back.
  task automatic send(input logic [3:0] sel, input logic [4:0] rs1, input logic [31:0] v1,
                      input logic [4:0] rs2, input logic [31:0] v2, input logic [31:0] imm,
                      input logic ui, input logic [4:0] rd, input logic wen,
                      input logic [31:0] ea, input logic [31:0] eb, input logic eill);
    exp_t e;
    int   k;
    in_valid = 1'b1; in_sel = sel; in_rs1 = rs1; in_rs1_val = v1;
    in_rs2 = rs2; in_rs2_val = v2; in_imm = imm; in_use_imm = ui;
    in_rd = rd; in_wen = wen;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.sel = sel; e.a = ea; e.b = eb; e.rd = rd; e.wen = wen; e.ill = eill;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_fwd();
    mem_fwd_en = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_fwd_en  = 1'b0; wb_fwd_rd  = '0; wb_fwd_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] sel_tab [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd12, 4'd5, 4'd6, 4'd10};

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_sel = 4'd3; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rs1_val = 32'h11; in_rs2_val = 32'h22;
    in_imm = 32'h33; in_use_imm = 1'b0; in_rd = 5'd4; in_wen = 1'b1;
    clear_fwd();

    // Reset held for two cycles with in_valid high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_sel", {28'd0, out_sel}, 32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle_valid", {31'd0, out_valid}, 32'd0);

    // No hazard, one-cycle latency
    out_ready = 1'b1;
    send(4'd0, 5'd3, 32'd5, 5'd4, 32'd7, 32'd0, 1'b0, 5'd1, 1'b1, 32'd5, 32'd7, 1'b0);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;

    // Forwarding priority: MEM over WB, register 0 never forwards, WB alone
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd2; mem_fwd_data = 32'hAA;
    wb_fwd_en  = 1'b1; wb_fwd_rd  = 5'd2; wb_fwd_data  = 32'hBB;
    send(4'd1, 5'd2, 32'h11, 5'd5, 32'h22, 32'd0, 1'b0, 5'd3, 1'b1, 32'hAA, 32'h22, 1'b0);
    mem_fwd_rd = 5'd0; wb_fwd_en = 1'b0;
    send(4'd2, 5'd0, 32'h33, 5'd2, 32'h44, 32'd0, 1'b0, 5'd4, 1'b0, 32'h0, 32'h44, 1'b0);
    mem_fwd_rd = 5'd3; wb_fwd_en = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'hCC;
    send(4'd3, 5'd7, 32'h55, 5'd3, 32'h66, 32'd0, 1'b0, 5'd5, 1'b1, 32'hCC, 32'hAA, 1'b0);
    in_valid = 1'b0;
    clear_fwd();
    @(posedge clk); #1;

    // Stall refresh of a register operand B
    out_ready = 1'b0;
    send(4'd7, 5'd1, 32'h10, 5'd6, 32'h66, 32'd0, 1'b0, 5'd6, 1'b1, 32'h10, 32'h1234, 1'b0);
    in_valid = 1'b0;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    wb_fwd_en = 1'b1; wb_fwd_rd = 5'd6; wb_fwd_data = 32'h1234;
    @(posedge clk); #1;
    clear_fwd();
    chk("stall_refresh_b", out_b, 32'h1234);
    chk("stall_keep_a", out_a, 32'h10);
    @(posedge clk); #1;
    chk("stall_hold_b", out_b, 32'h1234);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);

    // Immediate B is never overwritten while held
    out_ready = 1'b1;
    send(4'd8, 5'd0, 32'h99, 5'd6, 32'h66, 32'hFFFF_FFF0, 1'b1, 5'd7, 1'b1, 32'h0, 32'hFFFF_FFF0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    wb_fwd_en  = 1'b1; wb_fwd_rd  = 5'd6; wb_fwd_data  = 32'h1234;
    mem_fwd_en = 1'b1; mem_fwd_rd = 5'd6; mem_fwd_data = 32'h5555;
    @(posedge clk); #1;
    clear_fwd();
    chk("stall_imm_b", out_b, 32'hFFFF_FFF0);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Flush while FULL with a new op being offered
    send(4'd9, 5'd3, 32'h300, 5'd4, 32'h400, 32'd0, 1'b0, 5'd8, 1'b1, 32'h300, 32'h400, 1'b0);
    in_sel = 4'd5; in_rs1 = 5'd9; in_rs1_val = 32'hDEAD; in_rs2 = 5'd10; in_rs2_val = 32'hBEEF;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush_dropped", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream, one illegal opcode (12); opcode 10 is the highest legal one
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic ui;
      ui = i[0];
      send(sel_tab[i], 5'(i + 1), 32'h1000 + i, 5'(i + 9), 32'h2000 + i, 32'hF000_0000 | i,
           ui, 5'(i), ui, 32'h1000 + i, ui ? (32'hF000_0000 | i) : (32'h2000 + i), (i == 4));
      chk("stream_no_bubble", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    chk("final_idle", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
